// File: rtl/mem_access_initiator.sv
// mem_access_initiator: RV32 MEM-stage load/store initiator (pipeline req_* in, data-memory Mem*/mem_* out, load/store/err pulses and busy back)
module mem_access_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              MemREAD,
  output logic [1:0]        MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              store_done,
  output logic              req_err,
  output logic              busy
);
  localparam logic [2:0] IDLE = 3'd0, RD0 = 3'd1, RD1 = 3'd2, CAP = 3'd3, RESP = 3'd4, WR = 3'd5, ERR = 3'd6;
  logic [2:0]          r_state;
  logic [2:0]          r_f3;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_word0;
  logic                r_cross;
  logic [1:0]          r_rem, r_idx;
  logic                r_mem_read, r_load_valid, r_store_done, r_req_err;
  logic [1:0]          r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_write_data, r_load_data;
  logic [2:0]          w_size;
  logic [1:0]          w_off, w_szm1;
  logic                w_cross, w_illegal, w_split, w_sg;
  logic [2*DATA_W-1:0] w_dbl;
  logic [DATA_W-1:0]   w_sh, w_ld, w_wsh;
  always_comb begin
    w_size    = req_funct3[1] ? 3'd4 : req_funct3[0] ? 3'd2 : 3'd1;
    w_szm1    = {req_funct3[1], req_funct3[1] | req_funct3[0]};
    w_off     = req_addr[1:0];
    w_cross   = ({1'b0, w_off} + w_size) > 3'd4;
    w_illegal = (&req_funct3[1:0]) | (&req_funct3[2:1]) | (req_store & req_funct3[2]);
    // halfwords at odd offsets and unaligned words cannot use the wide write ports
    w_split   = (req_funct3[0] & w_off[0]) | (req_funct3[1] & (w_off != 2'd0));
    // a non-crossing load only needs the word arriving now; the upper word is don't-care
    w_dbl     = {mem_read_data, r_cross ? r_word0 : mem_read_data} >> {r_addr[1:0], 3'b000};
    w_sh      = w_dbl[DATA_W-1:0];
    w_sg      = ~r_f3[2];
    w_ld      = r_f3[1:0] == 2'b00 ? {{24{w_sg & w_sh[7]}}, w_sh[7:0]} :
                r_f3[1:0] == 2'b01 ? {{16{w_sg & w_sh[15]}}, w_sh[15:0]} : w_sh;
    w_wsh     = r_wdata >> {r_idx, 3'b000};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_f3             <= '0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_word0          <= '0;
      r_cross          <= 1'b0;
      r_rem            <= '0;
      r_idx            <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 2'b00;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_load_valid     <= 1'b0;
      r_load_data      <= '0;
      r_store_done     <= 1'b0;
      r_req_err        <= 1'b0;
    end else begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 2'b00;
      r_load_valid <= 1'b0;
      r_store_done <= 1'b0;
      r_req_err    <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_f3    <= req_funct3;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_cross <= w_cross;
          if (w_illegal) begin
            r_state   <= ERR;
            r_req_err <= 1'b1;
          end else if (!req_store) begin
            r_state       <= RD0;
            r_mem_read    <= 1'b1;
            r_mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
          end else begin
            r_state          <= WR;
            r_mem_address    <= req_addr;
            r_mem_write      <= w_split ? 2'b01 : req_funct3[1:0] + 2'd1;
            r_mem_write_data <= w_split ? {{(DATA_W-8){1'b0}}, req_wdata[7:0]} : req_wdata;
            r_store_done     <= ~w_split;
            r_rem            <= w_split ? w_szm1 : 2'd0;
            r_idx            <= 2'd1;
          end
        end
        RD0: begin
          r_state       <= r_cross ? RD1 : CAP;
          r_mem_read    <= r_cross;
          r_mem_address <= r_cross ? r_mem_address + ADDR_W'(4) : r_mem_address;
        end
        RD1: begin
          r_state <= CAP;
          r_word0 <= mem_read_data;
        end
        CAP: begin
          r_state      <= RESP;
          r_load_valid <= 1'b1;
          r_load_data  <= w_ld;
        end
        WR: if (r_rem == 2'd0) r_state <= IDLE;
        else begin
          r_mem_write      <= 2'b01;
          r_mem_address    <= r_addr + ADDR_W'(r_idx);
          r_mem_write_data <= {{(DATA_W-8){1'b0}}, w_wsh[7:0]};
          r_store_done     <= r_rem == 2'd1;
          r_rem            <= r_rem - 2'd1;
          r_idx            <= r_idx + 2'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy           = r_state != IDLE;
  assign req_ready      = ~busy;
  assign MemREAD        = r_mem_read;
  assign MemWrite       = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign load_valid     = r_load_valid;
  assign load_data      = r_load_data;
  assign store_done     = r_store_done;
  assign req_err        = r_req_err;
endmodule

// File: tb/tb_mem_access_initiator.sv
// tb_mem_access_initiator: table-driven bench for mem_access_initiator
module tb_mem_access_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_read_data = '0;
  logic        req_ready, MemREAD, load_valid, store_done, req_err, busy;
  logic [1:0]  MemWrite;
  logic [31:0] mem_address, mem_write_data, load_data;
  int total = 0, bad = 0;
  mem_access_initiator dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .MemREAD(MemREAD), .MemWrite(MemWrite),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .load_valid(load_valid), .load_data(load_data),
    .store_done(store_done), .req_err(req_err), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  always @(posedge clk) if (MemREAD) mem_read_data <= rd(mem_address);
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr, wd, m0, m1;
    int          nrd;
    logic [31:0] rda;
    int          lv;
    logic [31:0] ld;
    int          nwr;
    logic [1:0]  code;
    logic [31:0] wra, wrd;
    int          sd, err, nbusy;
  } vec_t;
  vec_t vt [16];
  int nrd, nwr, lv, sd, er, nb, viol;
  logic [31:0] ra [8], wa [8], wdv [8], ld;
  logic [1:0]  wc0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  task automatic sample(input int k);
    if (MemREAD) begin
      if (nrd < 8) ra[nrd] = mem_address;
      nrd++;
    end
    if (MemWrite != 2'b00) begin
      if (nwr == 0) wc0 = MemWrite;
      if (nwr < 8) begin
        wa[nwr] = mem_address;
        wdv[nwr] = mem_write_data;
      end
      nwr++;
    end
    if (load_valid) begin
      lv = k;
      ld = load_data;
    end
    if (store_done) sd = k;
    if (req_err) er = k;
    if (busy) nb++;
    if ((MemREAD && MemWrite != 2'b00) || req_ready == busy) viol++;
  endtask
  task automatic start(input int i);
    vec_t v;
    v = vt[i];
    mem[{v.addr[31:2], 2'b00}] = v.m0;
    mem[{v.addr[31:2], 2'b00} + 32'd4] = v.m1;
    nrd = 0; nwr = 0; lv = 0; sd = 0; er = 0; nb = 0; viol = 0; ld = '0; wc0 = '0;
    for (int j = 0; j < 8; j++) begin
      ra[j] = '0; wa[j] = '0; wdv[j] = '0;
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = v.st; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wd;
    @(posedge clk);
  endtask
  task automatic run(input int i);
    vec_t v;
    v = vt[i];
    start(i);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      sample(k);
      if (!busy) break;
    end
    chk($sformatf("v%0d_settled", i), {31'b0, busy}, 32'd0);
    chk($sformatf("v%0d_nrd", i), nrd, v.nrd);
    chk($sformatf("v%0d_rdaddr", i), ra[0], v.rda);
    chk($sformatf("v%0d_lvcyc", i), lv, v.lv);
    chk($sformatf("v%0d_ldata", i), ld, v.ld);
    chk($sformatf("v%0d_nwr", i), nwr, v.nwr);
    chk($sformatf("v%0d_wcode", i), {30'b0, wc0}, {30'b0, v.code});
    chk($sformatf("v%0d_waddr", i), wa[0], v.wra);
    chk($sformatf("v%0d_wdata", i), wdv[0], v.wrd);
    chk($sformatf("v%0d_sdcyc", i), sd, v.sd);
    chk($sformatf("v%0d_errcyc", i), er, v.err);
    chk($sformatf("v%0d_busy", i), nb, v.nbusy);
    chk($sformatf("v%0d_protocol", i), viol, 0);
  endtask
  initial begin
    vt[0]  = '{1'b0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 32'h100, 3, 32'hDEADBEEF, 0, 2'b00, 0, 0, 0, 0, 3};
    vt[1]  = '{1'b0, 3'b000, 32'h203, 0, 32'h80123456, 0, 1, 32'h200, 3, 32'hFFFFFF80, 0, 2'b00, 0, 0, 0, 0, 3};
    vt[2]  = '{1'b0, 3'b100, 32'h203, 0, 32'h80123456, 0, 1, 32'h200, 3, 32'h00000080, 0, 2'b00, 0, 0, 0, 0, 3};
    vt[3]  = '{1'b0, 3'b010, 32'h102, 0, 32'h11223344, 32'h55667788, 2, 32'h100, 4, 32'h77881122, 0, 2'b00, 0, 0, 0, 0, 4};
    vt[4]  = '{1'b0, 3'b001, 32'h102, 0, 32'h80011234, 0, 1, 32'h100, 3, 32'hFFFF8001, 0, 2'b00, 0, 0, 0, 0, 3};
    vt[5]  = '{1'b0, 3'b101, 32'h103, 0, 32'hAB000000, 32'h000000CD, 2, 32'h100, 4, 32'h0000CDAB, 0, 2'b00, 0, 0, 0, 0, 4};
    vt[6]  = '{1'b0, 3'b001, 32'h101, 0, 32'h00F00F00, 0, 1, 32'h100, 3, 32'hFFFFF00F, 0, 2'b00, 0, 0, 0, 0, 3};
    vt[7]  = '{1'b0, 3'b010, 32'hFFFFFFFE, 0, 32'hAABBCCDD, 32'h11223344, 2, 32'hFFFFFFFC, 4, 32'h3344AABB, 0, 2'b00, 0, 0, 0, 0, 4};
    vt[8]  = '{1'b1, 3'b001, 32'h402, 32'h1234BEEF, 0, 0, 0, 0, 0, 0, 1, 2'b10, 32'h402, 32'h1234BEEF, 1, 0, 1};
    vt[9]  = '{1'b1, 3'b000, 32'h005, 32'h123456A5, 0, 0, 0, 0, 0, 0, 1, 2'b01, 32'h005, 32'h123456A5, 1, 0, 1};
    vt[10] = '{1'b1, 3'b010, 32'h301, 32'hA1B2C3D4, 0, 0, 0, 0, 0, 0, 4, 2'b01, 32'h301, 32'h000000D4, 4, 0, 4};
    vt[11] = '{1'b1, 3'b001, 32'h403, 32'h0000BEEF, 0, 0, 0, 0, 0, 0, 2, 2'b01, 32'h403, 32'h000000EF, 2, 0, 2};
    vt[12] = '{1'b1, 3'b010, 32'h500, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 1, 2'b11, 32'h500, 32'hCAFEF00D, 1, 0, 1};
    vt[13] = '{1'b0, 3'b011, 32'h100, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1};
    vt[14] = '{1'b1, 3'b100, 32'h100, 32'h000000FF, 32'h12345678, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1};
    vt[15] = '{1'b0, 3'b111, 32'h100, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memread", {31'b0, MemREAD}, 32'd0);
    chk("rst_memwrite", {30'b0, MemWrite}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_lv", {31'b0, load_valid}, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_sd", {31'b0, store_done}, 32'd0);
    chk("rst_err", {31'b0, req_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) run(i);
    run(7);
    chk("wrap_rd1", ra[1], 32'h00000000);
    run(3);
    chk("cross_rd1", ra[1], 32'h104);
    run(10);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("split_addr%0d", j), wa[j], 32'h301 + j);
      chk($sformatf("split_data%0d", j), wdv[j], (32'hA1B2C3D4 >> (8 * j)) & 32'hFF);
    end
    start(10);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_w0", {30'b0, MemWrite}, 32'd1);
    @(negedge clk);
    chk("abort_w1_addr", mem_address, 32'h302);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_memwrite", {30'b0, MemWrite}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_sd", {31'b0, store_done}, 32'd0);
    rst = 1'b0;
    sd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (store_done || MemWrite != 2'b00) sd++;
    end
    chk("abort_quiet", sd, 0);
    run(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
